// File: rtl/nn_result_argmax.sv
// nn_result_argmax: collects per-lane network scores, finds the signed maximum
// with a sequential scan, and offers the result on a valid/ready interface.
module nn_result_argmax #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N_OUT = 5,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [N_OUT*WIDTH-1:0] in_data,
  input  logic [N_OUT-1:0]       in_vld,
  output logic                   cls_valid,
  input  logic                   cls_ready,
  output logic [IDX_W-1:0]       cls_idx,
  output logic [WIDTH-1:0]       cls_score,
  output logic [N_OUT*WIDTH-1:0] cls_scores,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic                   busy,
  output logic                   overrun
);

  typedef enum logic [1:0] {StCollect, StScan, StHold} state_e;

  state_e           state;
  logic [N_OUT-1:0] mask;
  logic [WIDTH-1:0] score [N_OUT];
  logic [IDX_W-1:0] scan_i;
  logic [IDX_W-1:0] max_idx;
  logic [WIDTH-1:0] max_val;

  logic [WIDTH-1:0] cand;
  logic             take;
  logic [WIDTH-1:0] nxt_max;
  logic [IDX_W-1:0] nxt_idx;
  logic             all_in;
  logic             last_lane;

  // Scan datapath: select the current lane and compare it against the running max.
  always_comb begin
    cand = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (scan_i == IDX_W'(k)) cand = score[k];
    end
    // Lane 0 seeds the max; strict compare keeps the lowest index on ties.
    take      = (scan_i == '0) || ($signed(cand) > $signed(max_val));
    nxt_max   = take ? cand : max_val;
    nxt_idx   = take ? scan_i : max_idx;
    all_in    = &(mask | in_vld);
    last_lane = (scan_i == IDX_W'(N_OUT - 1));
  end

  assign busy = (state != StCollect);

  // Frame FSM: capture lanes, scan for the max, then hold the result for the sink.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state      <= StCollect;
      mask       <= '0;
      for (int k = 0; k < N_OUT; k++) score[k] <= '0;
      scan_i     <= '0;
      max_idx    <= '0;
      max_val    <= '0;
      cls_valid  <= 1'b0;
      cls_idx    <= '0;
      cls_score  <= '0;
      cls_scores <= '0;
      frame_cnt  <= '0;
      overrun    <= 1'b0;
    end else begin
      unique case (state)
        StCollect: begin
          for (int k = 0; k < N_OUT; k++) begin
            if (in_vld[k]) score[k] <= in_data[k*WIDTH +: WIDTH];
          end
          mask <= mask | in_vld;
          if (all_in) begin
            state  <= StScan;
            scan_i <= '0;
          end
        end
        StScan: begin
          if (|in_vld) overrun <= 1'b1;
          max_val <= nxt_max;
          max_idx <= nxt_idx;
          scan_i  <= scan_i + 1'b1;
          if (last_lane) begin
            state     <= StHold;
            cls_valid <= 1'b1;
            cls_idx   <= nxt_idx;
            cls_score <= nxt_max;
            for (int k = 0; k < N_OUT; k++) cls_scores[k*WIDTH +: WIDTH] <= score[k];
          end
        end
        StHold: begin
          if (|in_vld) overrun <= 1'b1;
          if (cls_ready) begin
            cls_valid <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
            mask      <= '0;
            state     <= StCollect;
          end
        end
        default: state <= StCollect;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_result_argmax.sv
// Directed bench for nn_result_argmax with hand-computed expected results.
module tb_nn_result_argmax;

  localparam int WIDTH = 16;
  localparam int N_OUT = 5;
  localparam int IDX_W = 3;
  localparam int CNT_W = 16;

  logic                   ap_clk;
  logic                   ap_rst;
  logic [N_OUT*WIDTH-1:0] in_data;
  logic [N_OUT-1:0]       in_vld;
  logic                   cls_valid;
  logic                   cls_ready;
  logic [IDX_W-1:0]       cls_idx;
  logic [WIDTH-1:0]       cls_score;
  logic [N_OUT*WIDTH-1:0] cls_scores;
  logic [CNT_W-1:0]       frame_cnt;
  logic                   busy;
  logic                   overrun;

  int total = 0;
  int bad   = 0;

  nn_result_argmax #(
    .WIDTH(WIDTH),
    .N_OUT(N_OUT),
    .IDX_W(IDX_W),
    .CNT_W(CNT_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .cls_valid (cls_valid),
    .cls_ready (cls_ready),
    .cls_idx   (cls_idx),
    .cls_score (cls_score),
    .cls_scores(cls_scores),
    .frame_cnt (frame_cnt),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N_OUT*WIDTH-1:0] pack(input logic [WIDTH-1:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  // Present one cycle of lane valids; returns #1 after the capturing edge.
  task automatic drive(input logic [N_OUT-1:0] vld, input logic [N_OUT*WIDTH-1:0] data);
    in_vld  = vld;
    in_data = data;
    @(posedge ap_clk);
    #1;
    in_vld  = '0;
  endtask

  // Count edges until cls_valid rises, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!cls_valid && n < 40) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (!cls_valid) chk("valid_timeout", 128'(0), 128'(1));
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 128'(cls_valid), 128'(0));
    chk({tag, "_idx"}, 128'(cls_idx), 128'(0));
    chk({tag, "_score"}, 128'(cls_score), 128'(0));
    chk({tag, "_scores"}, 128'(cls_scores), 128'(0));
    chk({tag, "_cnt"}, 128'(frame_cnt), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_ovr"}, 128'(overrun), 128'(0));
  endtask

  logic [N_OUT*WIDTH-1:0] vec;
  int n;

  initial begin
    ap_rst    = 1'b0;
    in_vld    = '0;
    in_data   = '0;
    cls_ready = 1'b1;
    #1 ap_rst = 1'b1;
    #1;
    check_zero_outputs("rst");
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;

    // Frame 1: all lanes together, max at lane 2.
    vec = pack(16'h0100, 16'hFC00, 16'h0800, 16'h0200, 16'h07FF);
    drive(5'b11111, vec);
    chk("t1_busy", 128'(busy), 128'(1));
    wait_valid(n);
    chk("t1_latency", 128'(n), 128'(N_OUT));
    chk("t1_idx", 128'(cls_idx), 128'(2));
    chk("t1_score", 128'(cls_score), 128'(16'h0800));
    chk("t1_scores", 128'(cls_scores), 128'(vec));
    chk("t1_cnt_before", 128'(frame_cnt), 128'(0));
    @(posedge ap_clk);
    #1;
    chk("t1_valid_drop", 128'(cls_valid), 128'(0));
    chk("t1_cnt", 128'(frame_cnt), 128'(1));
    chk("t1_ovr", 128'(overrun), 128'(0));
    chk("t1_busy_idle", 128'(busy), 128'(0));

    // Frame 2: staggered lanes 4..0, all equal -> lowest index wins.
    for (int k = N_OUT - 1; k >= 0; k--) begin
      vec = '0;
      vec[k*WIDTH +: WIDTH] = 16'h0400;
      drive(5'(1 << k), vec);
    end
    wait_valid(n);
    chk("t2_latency", 128'(n), 128'(N_OUT));
    chk("t2_idx", 128'(cls_idx), 128'(0));
    chk("t2_score", 128'(cls_score), 128'(16'h0400));
    @(posedge ap_clk);
    #1;
    chk("t2_cnt", 128'(frame_cnt), 128'(2));

    // Frame 3: all negative, signed compare with tie on lanes 1/2.
    vec = pack(16'hFFFB, 16'hFFFD, 16'hFFFD, 16'hFFF9, 16'hFFF7);
    drive(5'b11111, vec);
    wait_valid(n);
    chk("t3_idx", 128'(cls_idx), 128'(1));
    chk("t3_score", 128'(cls_score), 128'(16'hFFFD));
    @(posedge ap_clk);
    #1;
    chk("t3_cnt", 128'(frame_cnt), 128'(3));

    // Frame 4: sink stalls in HOLD while a stray lane-3 valid arrives.
    cls_ready = 1'b0;
    vec = pack(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005);
    drive(5'b11111, vec);
    wait_valid(n);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        in_vld  = 5'b01000;
        in_data = pack(16'h0, 16'h0, 16'h0, 16'h1234, 16'h0);
      end
      @(posedge ap_clk);
      #1;
      in_vld = '0;
      chk("t4_hold_valid", 128'(cls_valid), 128'(1));
      chk("t4_hold_idx", 128'(cls_idx), 128'(4));
      chk("t4_hold_score", 128'(cls_score), 128'(16'h0005));
      chk("t4_hold_scores", 128'(cls_scores), 128'(vec));
    end
    chk("t4_ovr", 128'(overrun), 128'(1));
    chk("t4_cnt_stall", 128'(frame_cnt), 128'(3));
    cls_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("t4_valid_drop", 128'(cls_valid), 128'(0));
    chk("t4_cnt", 128'(frame_cnt), 128'(4));
    vec = pack(16'h0100, 16'hFC00, 16'h0800, 16'h0200, 16'h07FF);
    drive(5'b11111, vec);
    wait_valid(n);
    chk("t4b_idx", 128'(cls_idx), 128'(2));
    chk("t4b_score", 128'(cls_score), 128'(16'h0800));
    chk("t4b_ovr", 128'(overrun), 128'(1));
    @(posedge ap_clk);
    #1;
    chk("t4b_cnt", 128'(frame_cnt), 128'(5));

    // Reset during the second SCAN cycle aborts the frame.
    vec = pack(16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050);
    drive(5'b11111, vec);
    @(posedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    check_zero_outputs("t6_rst");
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    repeat (8) @(posedge ap_clk);
    #1;
    chk("t6_no_result", 128'(cls_valid), 128'(0));
    vec = pack(16'h0300, 16'h0100, 16'h0050, 16'h0600, 16'hF000);
    drive(5'b11111, vec);
    wait_valid(n);
    chk("t6_idx", 128'(cls_idx), 128'(3));
    chk("t6_score", 128'(cls_score), 128'(16'h0600));
    @(posedge ap_clk);
    #1;
    chk("t6_cnt", 128'(frame_cnt), 128'(1));

    // Lane 0 written twice before the others: last value wins, no overrun.
    drive(5'b00001, pack(16'h0010, 16'h0, 16'h0, 16'h0, 16'h0));
    drive(5'b00001, pack(16'h0900, 16'h0, 16'h0, 16'h0, 16'h0));
    chk("t5_not_busy", 128'(busy), 128'(0));
    drive(5'b11110, pack(16'h0, 16'h0100, 16'h0100, 16'h0100, 16'h0100));
    wait_valid(n);
    chk("t5_idx", 128'(cls_idx), 128'(0));
    chk("t5_score", 128'(cls_score), 128'(16'h0900));
    chk("t5_ovr", 128'(overrun), 128'(0));
    @(posedge ap_clk);
    #1;
    chk("t5_cnt", 128'(frame_cnt), 128'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
